// File: rtl/cross_bar_slave_port.sv
// Crossbar slave port: address decode, round-robin arbitration with ack-held grant,
// and in-order read-response routing. Optional master lock via CROSS_BAR_LOCK_EN.
module cross_bar_slave_port #(
  parameter int MASTER_N = 4,
  parameter int SLAVE_N  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SLAVE_ID = 0,
  parameter int OUTST_N  = 4
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [MASTER_N-1:0]          master_req,
  input  logic [MASTER_N*ADDR_W-1:0]   master_addr,
  input  logic [MASTER_N-1:0]          master_cmd,
  input  logic [MASTER_N*DATA_W-1:0]   master_wdata,
`ifdef CROSS_BAR_LOCK_EN
  input  logic [MASTER_N-1:0]          master_lock,
`endif
  output logic [MASTER_N-1:0]          master_ack,
  output logic [MASTER_N-1:0]          master_resp,
  output logic [DATA_W-1:0]            master_rdata,
  output logic                         slave_req,
  output logic [ADDR_W-1:0]            slave_addr,
  output logic                         slave_cmd,
  output logic [DATA_W-1:0]            slave_wdata,
  input  logic                         slave_ack,
  input  logic                         slave_resp,
  input  logic [DATA_W-1:0]            slave_rdata,
  output logic                         outst_full,
  output logic                         resp_err
);

  localparam int SLAVE_W = $clog2(SLAVE_N);
  localparam int MIDX_W  = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
  localparam int PTR_W   = $clog2(OUTST_N);
  localparam int CNT_W   = PTR_W + 1;

  logic [MIDX_W-1:0]   rr_ptr;
  logic                hold_q;
  logic [MASTER_N-1:0] grant_q;

  logic [MIDX_W-1:0]   fifo_mem [OUTST_N];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full_q, empty;

  logic [MASTER_N-1:0] match, elig, grant, sel;
  logic [MIDX_W-1:0]   gidx, next_ptr;
  logic [MIDX_W:0]     sum;
  logic                found, hs, push, pop, held_live;

  assign full_q = (count == CNT_W'(OUTST_N));
  assign empty  = (count == '0);

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < MASTER_N; i++)
      match[i] = (master_addr[i*ADDR_W + ADDR_W - SLAVE_W +: SLAVE_W] == SLAVE_W'(SLAVE_ID));
  end

  assign elig = master_req & match & (master_cmd | {MASTER_N{~full_q}});

  // Rotating priority search starting at rr_ptr; MASTER_N need not be a power of 2.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    if (hold_q) begin
      grant = grant_q;
    end else begin
      for (int unsigned k = 0; k < MASTER_N; k++) begin
        sum = {1'b0, rr_ptr} + (MIDX_W+1)'(k);
        if (sum >= (MIDX_W+1)'(MASTER_N))
          sum = sum - (MIDX_W+1)'(MASTER_N);
        if (!found && elig[sum[MIDX_W-1:0]]) begin
          grant[sum[MIDX_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  assign sel = grant & elig & {MASTER_N{aresetn}};

  always_comb begin
    gidx        = '0;
    slave_addr  = '0;
    slave_wdata = '0;
    slave_cmd   = 1'b0;
    for (int unsigned i = 0; i < MASTER_N; i++) begin
      if (grant[i])
        gidx = MIDX_W'(i);
      if (sel[i]) begin
        slave_addr  = slave_addr  | master_addr[i*ADDR_W +: ADDR_W];
        slave_wdata = slave_wdata | master_wdata[i*DATA_W +: DATA_W];
        slave_cmd   = slave_cmd   | master_cmd[i];
      end
    end
  end

  assign slave_req  = |sel;
  assign hs         = slave_req & slave_ack;
  assign master_ack = sel & {MASTER_N{slave_ack}};
  assign next_ptr   = (gidx == MIDX_W'(MASTER_N-1)) ? '0 : gidx + 1'b1;
  assign held_live  = |(grant_q & master_req & match);

  assign push = hs & ~slave_cmd;
  assign pop  = slave_resp & ~empty & aresetn;

  always_comb begin
    master_resp = '0;
    for (int unsigned i = 0; i < MASTER_N; i++)
      master_resp[i] = pop && (fifo_mem[rd_ptr] == MIDX_W'(i));
  end

  assign master_rdata = pop ? slave_rdata : '0;
  assign outst_full   = full_q & aresetn;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rr_ptr   <= '0;
      hold_q   <= 1'b0;
      grant_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (hs) begin
`ifdef CROSS_BAR_LOCK_EN
        if (|(sel & master_lock)) begin
          hold_q  <= 1'b1;
          grant_q <= grant;
        end else begin
          hold_q <= 1'b0;
          rr_ptr <= next_ptr;
        end
`else
        hold_q <= 1'b0;
        rr_ptr <= next_ptr;
`endif
      end else if (slave_req) begin
        hold_q  <= 1'b1;
        grant_q <= grant;
      end else if (hold_q && !held_live) begin
        hold_q <= 1'b0;
      end

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;

      if (slave_resp && empty)
        resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= gidx;
  end

endmodule

// File: doc/cross_bar_slave_port.md
Name: cross_bar_slave_port

Overview:
- Slave-side port of the crossbar, one instance per slave.
- Decodes master addresses against its own SLAVE_ID and round-robin arbitrates among matching masters with a slave req/ack handshake.
- Records the master index of every accepted read in an ordering FIFO, then routes in-order read responses back to the originating master.
- Successor to the one-hot-select slave mux: adds parametrised widths, ack-based grant holding, read-response return path and outstanding-read tracking.

Parameters:
MASTER_N, 4, number of masters
SLAVE_N, 4, number of slaves; SLAVE_W = $clog2(SLAVE_N) is derived, not overridable
ADDR_W, 32, address width; bits [ADDR_W-1:ADDR_W-SLAVE_W] select the slave
DATA_W, 32, write/read data width
SLAVE_ID, 0, index this port answers to (0..SLAVE_N-1)
OUTST_N, 4, max outstanding reads (ordering FIFO depth, power of 2, >=2)

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
master_req  in  MASTER_N  request per master
master_addr  in  MASTER_N x ADDR_W  address per master
master_cmd  in  MASTER_N  0 = read, 1 = write
master_wdata  in  MASTER_N x DATA_W  write data per master
master_ack  out  MASTER_N  request accepted this cycle (one-hot or zero)
master_resp  out  MASTER_N  read response valid (one-hot or zero)
master_rdata  out  DATA_W  read data, shared, qualified by master_resp
slave_req  out  1  request to slave
slave_addr  out  ADDR_W  forwarded address
slave_cmd  out  1  forwarded command
slave_wdata  out  DATA_W  forwarded write data
slave_ack  in  1  slave accepts current request
slave_resp  in  1  slave read response valid
slave_rdata  in  DATA_W  slave read data
outst_full  out  1  ordering FIFO full
resp_err  out  1  sticky flag: response received with no outstanding read

Behaviour:
- Interface timing: one clock (clk); reset is synchronous and active-low (aresetn). All state updates happen on rising clk.
- Reset (aresetn=0 at a clk edge) sets:
  - RR pointer = 0, hold_q = 0, grant_q = 0
  - FIFO empty, resp_err = 0
- While aresetn is low:
  - slave_req, master_ack and master_resp are forced to 0.
  - Data outputs are 0; outst_full = 0.
- Eligibility: elig[i] = master_req[i] & (addr slave field == SLAVE_ID) & (master_cmd[i] | !outst_full).
  - outst_full is the registered FIFO full state, so a read is never accepted into a full FIFO, even when a pop happens in the same cycle.
- Grant:
  - If hold_q=1, grant = grant_q.
  - Otherwise grant = the first elig bit at or after the RR pointer, wrapping MASTER_N-1 -> 0. Arbitration is combinational, with zero added latency.
- Slave request and mux:
  - slave_req = |(grant & elig).
  - slave_addr, slave_cmd and slave_wdata are the AND-OR mux of the granted master; all 0 when there is no grant.
- Handshake and acceptance: hs = slave_req & slave_ack.
  - master_ack[g] = hs for the granted master g.
  - On hs: pointer <= g+1 (mod MASTER_N), hold_q <= 0. If the command is a read, push g into the FIFO.
- Stall: slave_req & !slave_ack sets hold_q <= 1 and grant_q <= grant. The grant is frozen until ack.
  - Masters must hold req/addr/cmd/wdata stable until ack.
  - If the held master drops req anyway, clear hold_q and re-arbitrate next cycle. No ack is given.
- Throughput: one accepted transaction per cycle with back-to-back acks.
- Responses: on slave_resp with a non-empty FIFO:
  - master_resp[head] = 1, master_rdata = slave_rdata, pop.
- Unexpected response: slave_resp with an empty FIFO is ignored, drives no master_resp and sets resp_err = 1 until reset.
- FIFO bookkeeping:
  - Push and pop in the same cycle keep the count unchanged.
  - A pop on empty never underflows.
  - outst_full = (count == OUTST_N).
- Write responses: writes produce no response and do not occupy the FIFO.

Optional Feature:
- Macro: CROSS_BAR_LOCK_EN.
- Defined:
  - Adds input master_lock [MASTER_N].
  - On hs with master_lock[g]=1, set hold_q <= 1 and grant_q <= grant. The pointer is not advanced.
  - The lock persists until a hs with master_lock[g]=0, or until the master drops req.
  - A locked read blocked by outst_full keeps the lock and stalls the port.
- Undefined: the port is absent and arbitration is pure round-robin as above.

Test Plan:
- Masters 0,1,2 all issue writes to SLAVE_ID with slave_ack=1 constantly -> acks in order m0, m1, m2, m0, ... one per cycle; slave_wdata matches the granted master each cycle.
- Master 1 reads, slave_ack low for 3 cycles while master 3 also requests -> grant stays with m1 for all 4 cycles; m1 acked on cycle 4; m3 acked the next cycle.
- OUTST_N=4: master 0 issues 4 reads, acked, no responses -> outst_full=1 and a 5th read is not presented (slave_req=0); a concurrent write from m2 still passes.
- Reads accepted from m2, then m0, then m3; 3 slave_resp pulses with rdata 0xA, 0xB, 0xC -> master_resp to m2/0xA, m0/0xB, m3/0xC in order.
- slave_resp with an empty FIFO -> no master_resp; resp_err=1 until aresetn=0.
- aresetn=0 during a stall with 2 reads outstanding -> next cycle slave_req=0, FIFO empty, pointer=0; a subsequent m3 request is granted immediately.
